instr_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 16-instruction processor: sequences FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/instr_sequencer_pkg.sv | 31 +++
 rtl/instr_sequencer_if.sv | 43 ++++
 rtl/instr_sequencer_decode.sv | 32 +++
 rtl/instr_sequencer.sv | 156 +++++++++++++++
 tb/tb_instr_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// Module      : proc_pkg
// Description : Shared types and constants for the 16-instruction processor
//               control path (sequencer states, opcode encodings, PC width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int PC_W = 5;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } seq_state_t;

    // Opcodes 0-7 are ALU operations, 12-14 are NOPs
    localparam logic [3:0] OP_LDR  = 4'd8;
    localparam logic [3:0] OP_STR  = 4'd9;
    localparam logic [3:0] OP_B    = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_if.sv
// ============================================================================
// Module      : instr_sequencer_if
// Description : Control bundle between the sequencer (master) and the
//               datapath: IR fields, flags, DMEM handshake and control strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_sequencer_if #(
    parameter int PC_W = 5
);
    logic [3:0]      IR_opcode;
    logic [3:0]      IR_ARd;
    logic            ALU_zero;
    logic            DMEM_ready;
    logic [PC_W-1:0] PC_out;

    logic            CNTRL_IR_load;
    logic            CNTRL_write_en_ARd;
    logic            mux_ARd_or_15_sel;
    logic            mux_ALU_or_DMEM_sel;
    logic            CNTRL_DMEM_rd;
    logic            CNTRL_DMEM_wr;
    logic [PC_W-1:0] PC_next;
    logic            halted;

    modport master (
        input  IR_opcode, IR_ARd, ALU_zero, DMEM_ready, PC_out,
        output CNTRL_IR_load, CNTRL_write_en_ARd, mux_ARd_or_15_sel,
               mux_ALU_or_DMEM_sel, CNTRL_DMEM_rd, CNTRL_DMEM_wr,
               PC_next, halted
    );

    modport slave (
        output IR_opcode, IR_ARd, ALU_zero, DMEM_ready, PC_out,
        input  CNTRL_IR_load, CNTRL_write_en_ARd, mux_ARd_or_15_sel,
               mux_ALU_or_DMEM_sel, CNTRL_DMEM_rd, CNTRL_DMEM_wr,
               PC_next, halted
    );

endinterface

`default_nettype wire

// File: rtl/instr_sequencer_decode.sv
// ============================================================================
// Module      : seq_decode
// Description : Combinational opcode classifier for the instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_decode
    import proc_pkg::*;
(
    input  wire logic [3:0] opcode,
    output logic            is_alu,
    output logic            is_ld,
    output logic            is_st,
    output logic            is_br,
    output logic            is_beq,
    output logic            is_halt,
    output logic            writes_rd
);

    assign is_alu    = ~opcode[3];
    assign is_ld     = (opcode == OP_LDR);
    assign is_st     = (opcode == OP_STR);
    assign is_br     = (opcode == OP_B);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_halt   = (opcode == OP_HALT);
    // Unconditional register writers; BEQ depends on the sampled zero flag
    assign writes_rd = is_alu | is_ld | is_br;

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.
//               Optional retired-instruction counter: define SEQ_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer
    import proc_pkg::*;
#(
    parameter int NUM_INSTR = 16,
    parameter int PC_W      = proc_pkg::PC_W,
    parameter int MEM_TMO   = 15
) (
    input  wire logic          CLOCK_50,
    input  wire logic          RESET_N,
    instr_sequencer_if.master  bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]        retired_cnt
`endif
);

    localparam logic [2:0] S_FETCH  = FETCH;
    localparam logic [2:0] S_DECODE = DECODE;
    localparam logic [2:0] S_EXEC   = EXEC;
    localparam logic [2:0] S_MEM    = MEM;
    localparam logic [2:0] S_WB     = WB;
    localparam logic [2:0] S_HALT   = HALT;

    localparam int TMO_W = $clog2(MEM_TMO + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [3:0]       r_opcode;
    logic [3:0]       r_ard;
    logic             r_taken;
    logic [TMO_W-1:0] r_tmo;

    logic [3:0]       w_dec_op;
    logic             w_is_alu, w_is_ld, w_is_st, w_is_br, w_is_beq, w_is_halt;
    logic             w_writes_rd;
    logic             w_br_taken;
    logic             w_wr_en;
    logic             w_jump;
    logic [PC_W-1:0]  w_pc_inc;

    // In DECODE the live IR is classified (HALT detect); afterwards the latched copy
    assign w_dec_op = (r_state == S_DECODE) ? bus.IR_opcode : r_opcode;

    seq_decode u_decode (
        .opcode    (w_dec_op),
        .is_alu    (w_is_alu),
        .is_ld     (w_is_ld),
        .is_st     (w_is_st),
        .is_br     (w_is_br),
        .is_beq    (w_is_beq),
        .is_halt   (w_is_halt),
        .writes_rd (w_writes_rd)
    );

    assign w_br_taken = w_is_br | (w_is_beq & r_taken);
    assign w_wr_en    = w_writes_rd | (w_is_beq & r_taken);
    // Any write landing in R15 wins over PC_next inside the register file
    assign w_jump     = w_br_taken | ((w_is_alu | w_is_ld) & (r_ard == 4'hF));
    assign w_pc_inc   = (bus.PC_out == PC_W'(NUM_INSTR - 1)) ? '0
                                                             : bus.PC_out + PC_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_is_halt ? S_HALT : S_EXEC;
            S_EXEC:   w_state_nxt = (w_is_ld | w_is_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.DMEM_ready)
                    w_state_nxt = S_WB;
                else if (r_tmo == TMO_W'(MEM_TMO - 1))
                    w_state_nxt = S_HALT;
            end
            S_WB:     w_state_nxt = S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
            r_ard    <= '0;
            r_taken  <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DECODE) begin
                r_opcode <= bus.IR_opcode;
                r_ard    <= bus.IR_ARd;
            end
            if (r_state == S_EXEC)
                r_taken <= bus.ALU_zero;
            if (r_state == S_MEM)
                r_tmo <= r_tmo + TMO_W'(1);
            else
                r_tmo <= '0;
        end
    end

    // Outputs are gated by RESET_N so an asserted reset clears them in the same cycle
    always_comb begin
        bus.CNTRL_IR_load       = 1'b0;
        bus.CNTRL_write_en_ARd  = 1'b0;
        bus.mux_ARd_or_15_sel   = 1'b0;
        bus.mux_ALU_or_DMEM_sel = 1'b0;
        bus.CNTRL_DMEM_rd       = 1'b0;
        bus.CNTRL_DMEM_wr       = 1'b0;
        bus.halted              = 1'b0;
        bus.PC_next             = bus.PC_out;
        if (!RESET_N) begin
            bus.PC_next = '0;
        end else begin
            case (r_state)
                S_FETCH: bus.CNTRL_IR_load = 1'b1;
                S_MEM: begin
                    bus.CNTRL_DMEM_rd = w_is_ld;
                    bus.CNTRL_DMEM_wr = w_is_st;
                end
                S_WB: begin
                    bus.CNTRL_write_en_ARd  = w_wr_en;
                    bus.mux_ARd_or_15_sel   = w_br_taken;
                    bus.mux_ALU_or_DMEM_sel = w_is_ld;
                    bus.PC_next             = w_jump ? bus.PC_out : w_pc_inc;
                end
                S_HALT:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] r_retired_cnt;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            r_retired_cnt <= '0;
        else if ((r_state == S_WB) && (r_retired_cnt != 16'hFFFF))
            r_retired_cnt <= r_retired_cnt + 16'd1;
    end

    assign retired_cnt = r_retired_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    logic CLOCK_50 = 1'b0;
    logic RESET_N;
    int   total = 0;
    int   bad   = 0;

    instr_sequencer_if #(.PC_W(5)) bus ();

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    instr_sequencer dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus)
`ifdef SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    initial begin
        RESET_N        = 1'b0;
        bus.IR_opcode  = 4'd0;
        bus.IR_ARd     = 4'd0;
        bus.ALU_zero   = 1'b0;
        bus.DMEM_ready = 1'b0;
        bus.PC_out     = 5'd4;
        repeat (2) @(posedge CLOCK_50);
        #2;
        chk("rst_ir_load", 32'(bus.CNTRL_IR_load), 0);
        chk("rst_pc_next", 32'(bus.PC_next), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_strobes", 32'({bus.CNTRL_write_en_ARd, bus.mux_ARd_or_15_sel,
                                bus.mux_ALU_or_DMEM_sel, bus.CNTRL_DMEM_rd,
                                bus.CNTRL_DMEM_wr}), 0);

        // ALU op 3 at PC 0
        bus.PC_out = 5'd0; bus.IR_opcode = 4'd3; bus.IR_ARd = 4'd2;
        RESET_N = 1'b1;
        #1;
        chk("alu_c1_ir_load", 32'(bus.CNTRL_IR_load), 1);
        chk("alu_c1_we", 32'(bus.CNTRL_write_en_ARd), 0);
        tick();
        chk("alu_c2_ir_load", 32'(bus.CNTRL_IR_load), 0);
        chk("alu_c2_pc_next", 32'(bus.PC_next), 0);
        tick();
        chk("alu_c3_we", 32'(bus.CNTRL_write_en_ARd), 0);
        tick();
        chk("alu_wb_we", 32'(bus.CNTRL_write_en_ARd), 1);
        chk("alu_wb_sels", 32'({bus.mux_ARd_or_15_sel, bus.mux_ALU_or_DMEM_sel}), 0);
        chk("alu_wb_pc_next", 32'(bus.PC_next), 1);
        tick();
        chk("alu_next_we", 32'(bus.CNTRL_write_en_ARd), 0);
        chk("alu_next_ir_load", 32'(bus.CNTRL_IR_load), 1);
`ifdef SEQ_PERF_CNT_EN
        chk("retired_after_alu", 32'(retired_cnt), 1);
`endif

        // LDR at PC 1, stray DMEM_ready before MEM, real ready in 3rd MEM cycle
        bus.PC_out = 5'd1; bus.IR_opcode = 4'd8; bus.IR_ARd = 4'd4;
        bus.DMEM_ready = 1'b1;
        tick();
        tick();
        bus.DMEM_ready = 1'b0;
        tick();
        chk("ldr_mem1_rdwr", 32'({bus.CNTRL_DMEM_rd, bus.CNTRL_DMEM_wr}), 2);
        tick();
        chk("ldr_mem2_rd", 32'(bus.CNTRL_DMEM_rd), 1);
        tick();
        chk("ldr_mem3_rd", 32'(bus.CNTRL_DMEM_rd), 1);
        bus.DMEM_ready = 1'b1;
        tick();
        bus.DMEM_ready = 1'b0;
        chk("ldr_wb_rd", 32'(bus.CNTRL_DMEM_rd), 0);
        chk("ldr_wb_we", 32'(bus.CNTRL_write_en_ARd), 1);
        chk("ldr_wb_sel_dmem", 32'(bus.mux_ALU_or_DMEM_sel), 1);
        chk("ldr_wb_pc_next", 32'(bus.PC_next), 2);
        tick();
        chk("ldr_next_we", 32'(bus.CNTRL_write_en_ARd), 0);

        // BEQ taken at PC 2
        bus.PC_out = 5'd2; bus.IR_opcode = 4'd11; bus.IR_ARd = 4'd0;
        tick();
        tick();
        bus.ALU_zero = 1'b1;
        tick();
        bus.ALU_zero = 1'b0;
        chk("beq_t_we", 32'(bus.CNTRL_write_en_ARd), 1);
        chk("beq_t_sel15", 32'(bus.mux_ARd_or_15_sel), 1);
        tick();

        // BEQ not taken at PC 7
        bus.PC_out = 5'd7; bus.IR_opcode = 4'd11;
        tick();
        tick();
        tick();
        chk("beq_nt_we", 32'(bus.CNTRL_write_en_ARd), 0);
        chk("beq_nt_sel15", 32'(bus.mux_ARd_or_15_sel), 0);
        chk("beq_nt_pc_next", 32'(bus.PC_next), 8);
        tick();

        // ALU op at PC 15 wraps to 0
        bus.PC_out = 5'd15; bus.IR_opcode = 4'd0; bus.IR_ARd = 4'd1;
        tick();
        tick();
        tick();
        chk("wrap_pc_next", 32'(bus.PC_next), 0);
        chk("wrap_we", 32'(bus.CNTRL_write_en_ARd), 1);
        tick();

        // Reset asserted in the middle of an LDR MEM phase
        bus.PC_out = 5'd3; bus.IR_opcode = 4'd8; bus.IR_ARd = 4'd6;
        tick();
        tick();
        tick();
        chk("rstmid_rd_before", 32'(bus.CNTRL_DMEM_rd), 1);
        RESET_N = 1'b0;
        #1;
        chk("rstmid_rd", 32'(bus.CNTRL_DMEM_rd), 0);
        chk("rstmid_pc_next", 32'(bus.PC_next), 0);
        chk("rstmid_ir_halt", 32'({bus.CNTRL_IR_load, bus.halted}), 0);
`ifdef SEQ_PERF_CNT_EN
        chk("rstmid_retired", 32'(retired_cnt), 0);
`endif
        @(posedge CLOCK_50);
        #2;
        RESET_N = 1'b1;
        #1;
        chk("rstmid_fetch_ir_load", 32'(bus.CNTRL_IR_load), 1);

        // STR with no DMEM_ready times out into HALT
        bus.PC_out = 5'd0; bus.IR_opcode = 4'd9; bus.IR_ARd = 4'd5;
        tick();
        tick();
        tick();
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("tmo_mem%0d_wr_halt", i), 32'({bus.CNTRL_DMEM_wr, bus.halted}), 2);
            tick();
        end
        chk("tmo_halted", 32'(bus.halted), 1);
        chk("tmo_wr_we", 32'({bus.CNTRL_DMEM_wr, bus.CNTRL_write_en_ARd}), 0);
        bus.DMEM_ready = 1'b1;
        tick();
        tick();
        chk("tmo_halt_absorbing", 32'(bus.halted), 1);
        chk("tmo_halt_we", 32'(bus.CNTRL_write_en_ARd), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
